// File: rtl/adc_sample_averager.sv
// adc_sample_averager: per-channel block averaging of 2^AVG_LOG2 packed ADC frames with registered valid/ready output
module adc_sample_averager #(
    parameter int NUM_CHANNELS = 2,
    parameter int WORD_WIDTH   = 16,
    parameter int SAMPLE_WIDTH = 12,
    parameter int SAMPLE_LSB   = 1,
    parameter int AVG_LOG2     = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [NUM_CHANNELS*WORD_WIDTH-1:0]   in_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] out_data_o,
    output logic                                 overrun_o,
    input  logic                                 overrun_clr_i,
    output logic [15:0]                          frame_count_o
);
    localparam int ACC_W = SAMPLE_WIDTH + AVG_LOG2;
    localparam int PH_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [PH_W-1:0] LAST = PH_W'((1 << AVG_LOG2) - 1);

    if (SAMPLE_LSB + SAMPLE_WIDTH > WORD_WIDTH) begin : g_bad_field
        $error("sample field does not fit inside its word");
    end

    logic [ACC_W-1:0] acc [NUM_CHANNELS];
    logic [ACC_W-1:0] sum [NUM_CHANNELS];
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] avg;
    logic [PH_W-1:0] phase;
    logic accept;
    logic complete;
    logic unused_bits;

    // word bits outside the sample field are deliberately ignored
    assign unused_bits = ^in_data_i;
    assign accept = in_valid_i & in_ready_o;
    assign complete = accept && (phase == LAST);

    // running sum including the current sample, and its truncated mean
    always_comb begin
        sum = '{default: '0};
        avg = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sum[c] = acc[c] + ACC_W'(in_data_i[c*WORD_WIDTH+SAMPLE_LSB +: SAMPLE_WIDTH]);
            avg[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sum[c][AVG_LOG2 +: SAMPLE_WIDTH];
        end
    end

    // accumulation, completion, output handshake and sticky overrun
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_ready_o    <= 1'b0;
            out_valid_o   <= 1'b0;
            out_data_o    <= '0;
            overrun_o     <= 1'b0;
            frame_count_o <= '0;
            phase         <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= '0;
        end else begin
            in_ready_o <= 1'b1;
            if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
            if (overrun_clr_i) overrun_o <= 1'b0;
            if (complete) begin
                out_valid_o   <= 1'b1;
                out_data_o    <= avg;
                frame_count_o <= frame_count_o + 16'd1;
                phase         <= '0;
                for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= '0;
                if (out_valid_o && !out_ready_i) overrun_o <= 1'b1;
            end else if (accept) begin
                phase <= phase + PH_W'(1);
                for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= sum[c];
            end
        end
    end
endmodule
